uartrx: RTL



---
 rtl/uartrx.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uartrx.sv
`default_nettype none
// ============================================================================
// Module      : uartrx
// Description : 8N1 UART receiver for the serial console path. The rx pin
//               goes through a 2-flop synchroniser; the FSM checks the start
//               bit at half a bit time, then takes the eight data bits (LSB
//               first) and the stop bit at mid-bit. Each good byte is shown
//               on d with a one-cycle valid strobe. A low stop bit gives a
//               one-cycle framing_err strobe instead, and the FSM then waits
//               for the line to return high before it will accept a new
//               start bit.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CLKDIV       clocks per bit (>= 8); the bit-time counter is 16 bits wide
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low (0 = reset)
//   rx           serial line, asynchronous to clk, idles high
//   d[7:0]       last correctly received byte
//   valid        one-cycle strobe: d updated this cycle
//   framing_err  one-cycle strobe: stop bit sampled low, byte discarded
//   busy         high while a frame is in progress (Start, Data, Stop)
//   leds[1:0]    current state encoding, for debug
// Build options:
//   UARTRX_MAJORITY_EN  when defined, every sample point takes a 2-of-3
//                       majority over target-1, target and target+1. The
//                       state advances at target+1, so valid comes one clock
//                       later than in the default single-sample build.
// ============================================================================
module uartrx #(
    parameter int unsigned CLKDIV = 100000000 / 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] d,
    output logic       valid,
    output logic       framing_err,
    output logic       busy,
    output logic [1:0] leds
);

    // Recover uses code 4 so that its low two bits show as 0 (Idle) on leds,
    // while it stays a separate state inside the FSM.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

`ifdef UARTRX_MAJORITY_EN
    // The vote is complete at target+1. After each advance the counter
    // restarts at 1, not 0, so the next sample point stays at mid-bit.
    localparam logic [15:0] START_DECIDE  = 16'(CLKDIV / 2);
    localparam logic [15:0] BIT_DECIDE    = 16'(CLKDIV);
    localparam logic [15:0] PHASE_RESTART = 16'd1;
`else
    localparam logic [15:0] START_DECIDE  = 16'(CLKDIV / 2 - 1);
    localparam logic [15:0] BIT_DECIDE    = 16'(CLKDIV - 1);
    localparam logic [15:0] PHASE_RESTART = 16'd0;
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]  sync_q,     sync_d;
    state_t      state_q,    state_d;
    logic [15:0] bitclock_q, bitclock_d;
    logic [2:0]  bitcount_q, bitcount_d;
    logic [7:0]  shift_q,    shift_d;
    logic [7:0]  d_q,        d_d;
    logic        valid_q,    valid_d;
    logic        ferr_q,     ferr_d;

    logic        rx_s;
    logic        bit_vote;
    logic        in_frame;

    // Two-flop synchroniser. The newest sample enters at bit 0.
    assign sync_d   = {sync_q[0], rx};
    assign rx_s     = sync_q[1];
    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);

    // ------------------------------------------------------------------
    // Sample-point decision
    // ------------------------------------------------------------------
`ifdef UARTRX_MAJORITY_EN
    // Holds the two earlier samples (taken at target-1 and target). The
    // third vote is the live rx_s at target+1.
    logic [1:0]  early_q, early_d;
    logic [15:0] decide_pt;

    assign decide_pt = (state_q == ST_START) ? START_DECIDE : BIT_DECIDE;

    always_comb begin
        early_d = early_q;
        if (in_frame) begin
            if (bitclock_q == decide_pt - 16'd2) begin
                early_d[0] = rx_s;
            end
            if (bitclock_q == decide_pt - 16'd1) begin
                early_d[1] = rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            early_q <= 2'b11;
        end else begin
            early_q <= early_d;
        end
    end

    assign bit_vote = (early_q[0] & early_q[1]) |
                      (early_q[0] & rx_s)       |
                      (early_q[1] & rx_s);
`else
    assign bit_vote = rx_s;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bitclock_d = bitclock_q;
        bitcount_d = bitcount_q;
        shift_d    = shift_q;
        d_d        = d_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bitclock_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (bitclock_q == START_DECIDE) begin
                    if (!bit_vote) begin
                        state_d    = ST_DATA;
                        bitclock_d = PHASE_RESTART;
                        bitcount_d = '0;
                    end else begin
                        // The line went back high before mid start bit:
                        // treat it as a glitch and drop it without a strobe.
                        state_d    = ST_IDLE;
                        bitclock_d = '0;
                    end
                end else begin
                    bitclock_d = bitclock_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (bitclock_q == BIT_DECIDE) begin
                    shift_d    = {bit_vote, shift_q[7:1]};
                    bitclock_d = PHASE_RESTART;
                    bitcount_d = bitcount_q + 3'd1;
                    if (bitcount_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    bitclock_d = bitclock_q + 16'd1;
                end
            end

            ST_STOP: begin
                // The FSM leaves at mid stop bit. This lets a start bit that
                // follows the stop bit with no gap be accepted.
                if (bitclock_q == BIT_DECIDE) begin
                    bitclock_d = '0;
                    if (bit_vote) begin
                        d_d     = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_RECOVER;
                    end
                end else begin
                    bitclock_d = bitclock_q + 16'd1;
                end
            end

            ST_RECOVER: begin
                // While the line is held low (a break), stay here. Only a
                // return to idle-high re-arms start detection, so a break
                // cannot produce repeated frames.
                bitclock_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                bitclock_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b11;
            state_q    <= ST_IDLE;
            bitclock_q <= '0;
            bitcount_q <= '0;
            shift_q    <= '0;
            d_q        <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            bitclock_q <= bitclock_d;
            bitcount_q <= bitcount_d;
            shift_q    <= shift_d;
            d_q        <= d_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign d           = d_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign busy        = in_frame;
    assign leds        = state_q[1:0];

endmodule
`default_nettype wire
